// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data accesses onto one SRAM-like bus, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN to alternate grants when both sides wait; otherwise data wins.
module mem_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        stall_req
);

  // state  | meaning
  // S_IDLE | no transaction outstanding; arbitrate pending requests
  // S_ADDR | bus_req high, waiting for bus_addr_ok
  // S_DATA | address accepted, waiting for bus_data_ok
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t state;
  logic   owner_d;
  logic   drop;
  logic   grant_any;
  logic   grant_d;
  logic   data_ret;

  assign grant_any = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  // With both pending, serve whichever side did not get the previous grant.
  assign grant_d = d_req & (~i_req | ~last_d);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_d <= 1'b0;
    end else if (state == S_IDLE && grant_any) begin
      last_d <= grant_d;
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      owner_d   <= 1'b0;
      drop      <= 1'b0;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_size  <= 2'b00;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            state   <= S_ADDR;
            bus_req <= 1'b1;
            owner_d <= grant_d;
            drop    <= 1'b0;
            if (grant_d) begin
              bus_addr  <= d_addr;
              bus_wr    <= d_wr;
              bus_size  <= d_size;
              bus_wdata <= d_wdata;
            end else begin
              bus_addr  <= i_addr;
              bus_wr    <= 1'b0;
              bus_size  <= 2'b10;
              bus_wdata <= 32'h0;
            end
          end
        end
        S_ADDR: begin
          // An unaccepted fetch can simply be withdrawn; an accepted one must run to completion.
          if (!owner_d && flush && !bus_addr_ok) begin
            state   <= S_IDLE;
            bus_req <= 1'b0;
          end else if (bus_addr_ok) begin
            state   <= S_DATA;
            bus_req <= 1'b0;
            if (!owner_d && flush) drop <= 1'b1;
          end
        end
        S_DATA: begin
          if (bus_data_ok) begin
            state <= S_IDLE;
            drop  <= 1'b0;
          end else if (!owner_d && flush) begin
            drop <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

  assign data_ret = (state == S_DATA) && bus_data_ok;

  // A flush coinciding with the data return also kills the fetch completion.
  assign i_done  = data_ret & ~owner_d & ~drop & ~flush;
  assign d_done  = data_ret & owner_d;
  assign i_rdata = i_done ? bus_rdata : 32'h0;
  assign d_rdata = d_done ? bus_rdata : 32'h0;

  assign stall_req = (i_req & ~i_done & ~flush) | (d_req & ~d_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a bus responder,
// with a scoreboard monitor comparing completions and grant decisions to a policy-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn, flush;
  logic        i_req, d_req, d_wr;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_size;
  logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata, bus_rdata;
  logic        i_done, d_done, bus_req, bus_wr, bus_addr_ok, bus_data_ok, stall_req;
  logic [1:0]  bus_size;

  bit          slave_auto;
  logic        m_addr_ok, m_data_ok, s_addr_ok, s_data_ok;
  logic [31:0] m_rdata, s_rdata;

  assign bus_addr_ok = slave_auto ? s_addr_ok : m_addr_ok;
  assign bus_data_ok = slave_auto ? s_data_ok : m_data_ok;
  assign bus_rdata   = slave_auto ? s_rdata   : m_rdata;

  mem_arbiter dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // Scoreboard state
  logic [31:0] i_q[$];
  logic [31:0] d_q[$];
  logic [31:0] addr_log[$];
  bit          i_inflight, last_d_model, i_done_seen, d_done_seen, bus_req_prev;
  logic        prev_i, prev_d, prev_d_wr;
  logic [1:0]  prev_d_size;
  logic [31:0] prev_i_addr, prev_d_addr, prev_d_wdata;

  always @(negedge clk) begin : monitor
    bit exp_d;
    if (!resetn) begin
      check("rst_bus_req", {31'b0, bus_req}, 32'h0);
      check("rst_dones", {30'b0, i_done, d_done}, 32'h0);
      i_q.delete();
      d_q.delete();
      i_inflight   = 1'b0;
      last_d_model = 1'b0;
      bus_req_prev = 1'b0;
      i_done_seen  = 1'b0;
      d_done_seen  = 1'b0;
    end else begin
      check("done_exclusive", {31'b0, i_done & d_done}, 32'h0);
      check("stall_req", {31'b0, stall_req},
            {31'b0, (i_req & ~i_done & ~flush) | (d_req & ~d_done)});
      if (!i_done) check("i_rdata_idle", i_rdata, 32'h0);
      if (!d_done) check("d_rdata_idle", d_rdata, 32'h0);
      if (flush && i_inflight) begin
        i_inflight = 1'b0;
        if (i_q.size() > 0) void'(i_q.pop_front());
      end
      if (i_done) begin
        if (i_q.size() == 0) check("i_done_unexpected", {31'b0, i_done}, 32'h0);
        else check("i_rdata", i_rdata, i_q.pop_front());
        i_inflight = 1'b0;
      end
      if (d_done) begin
        if (d_q.size() == 0) check("d_done_unexpected", {31'b0, d_done}, 32'h0);
        else check("d_rdata", d_rdata, d_q.pop_front());
      end
      i_done_seen = i_done;
      d_done_seen = d_done;
      // bus_req rises exactly one cycle after a grant decided on the previous cycle's requests
      if (bus_req && !bus_req_prev) begin
        if (!prev_i && !prev_d) check("grant_without_req", {31'b0, bus_req}, 32'h0);
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = prev_d && (!prev_i || !last_d_model);
`else
        exp_d = prev_d;
`endif
        check("grant_addr", bus_addr, exp_d ? prev_d_addr : prev_i_addr);
        check("grant_wr", {31'b0, bus_wr}, {31'b0, exp_d ? prev_d_wr : 1'b0});
        check("grant_size", {30'b0, bus_size}, {30'b0, exp_d ? prev_d_size : 2'b10});
        if (exp_d) check("grant_wdata", bus_wdata, prev_d_wdata);
        last_d_model = exp_d;
        if (!exp_d) i_inflight = 1'b1;
        addr_log.push_back(bus_addr);
      end
      bus_req_prev = bus_req;
    end
    prev_i       = i_req;
    prev_d       = d_req;
    prev_i_addr  = i_addr;
    prev_d_addr  = d_addr;
    prev_d_wr    = d_wr;
    prev_d_size  = d_size;
    prev_d_wdata = d_wdata;
  end

  // Randomized bus responder
  bit          acc;
  logic [31:0] cap_addr;
  logic        cap_wr;
  int          phase, dly;

  always @(negedge clk) begin
    acc = resetn && bus_req && bus_addr_ok;
    if (acc) begin
      cap_addr = bus_addr;
      cap_wr   = bus_wr;
    end
  end

  initial begin
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h0; phase = 0; dly = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn || !slave_auto) begin
        s_addr_ok = 1'b0; s_data_ok = 1'b0; phase = 0;
        continue;
      end
      if (s_data_ok) begin
        s_data_ok = 1'b0;
        phase = 0;
      end
      if (acc) begin
        phase = 1;
        dly = $urandom_range(0, 3);
      end
      s_addr_ok = 1'b0;
      if (phase == 1) begin
        if (dly == 0) begin
          s_data_ok = 1'b1;
          s_rdata   = cap_wr ? 32'h0 : mem_fn(cap_addr);
          phase     = 2;
        end else dly--;
      end else if (phase == 0 && bus_req) begin
        s_addr_ok = ($urandom_range(0, 2) == 0);
      end
    end
  end

  bit i_busy, d_busy;

  task automatic drive_cycle(input bit allow_new);
    tick();
    flush = 1'b0;
    if (i_busy && i_done_seen) begin i_busy = 1'b0; i_req = 1'b0; end
    if (d_busy && d_done_seen) begin d_busy = 1'b0; d_req = 1'b0; end
    if (i_busy && i_inflight && $urandom_range(0, 7) == 0) begin
      flush = 1'b1; i_req = 1'b0; i_busy = 1'b0;
    end else if (!i_busy && $urandom_range(0, 9) == 0) begin
      flush = 1'b1;
    end
    if (allow_new && !flush && !i_busy && $urandom_range(0, 3) == 0) begin
      i_addr = $urandom & 32'hFFFF_FFFC;
      i_req = 1'b1; i_busy = 1'b1;
      i_q.push_back(mem_fn(i_addr));
    end
    if (allow_new && !d_busy && $urandom_range(0, 3) == 0) begin
      d_wr = 1'($urandom_range(0, 1));
      d_size = 2'($urandom_range(0, 2));
      d_addr = $urandom;
      d_wdata = $urandom;
      d_req = 1'b1; d_busy = 1'b1;
      d_q.push_back(d_wr ? 32'h0 : mem_fn(d_addr));
    end
  endtask

  initial begin
    int base;
    int k;
    resetn = 1'b0; flush = 1'b0; i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_wr = 1'b0; d_size = 2'b00; d_addr = 32'h0; d_wdata = 32'h0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0; slave_auto = 1'b0;
    i_busy = 1'b0; d_busy = 1'b0;
    repeat (3) tick();
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_bus_ctl", {29'b0, bus_wr, bus_size}, 32'h0);
    resetn = 1'b1;
    tick();

    // Single fetch: minimum-latency round trip
    i_req = 1'b1; i_addr = 32'hBFC0_0000; i_q.push_back(32'h3C08_0001);
    tick();
    check("a_bus_req", {31'b0, bus_req}, 32'h1);
    m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0;
    check("a_bus_req_data", {31'b0, bus_req}, 32'h0);
    tick();
    m_data_ok = 1'b1; m_rdata = 32'h3C08_0001;
    #1 check("a_i_done", {31'b0, i_done}, 32'h1);
    check("a_i_rdata", i_rdata, 32'h3C08_0001);
    tick();
    m_data_ok = 1'b0; i_req = 1'b0;
    #1 check("a_stall_after", {31'b0, stall_req}, 32'h0);
    tick();

    // Simultaneous fetch and load: load goes first, fetch after d_done
    i_req = 1'b1; i_addr = 32'hBFC0_0010; i_q.push_back(32'h3333_4444);
    d_req = 1'b1; d_wr = 1'b0; d_size = 2'b10; d_addr = 32'h8000_1000; d_wdata = 32'h0;
    d_q.push_back(32'h1111_2222);
    tick();
    check("b_first_addr", bus_addr, 32'h8000_1000);
    m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0;
    tick();
    m_data_ok = 1'b1; m_rdata = 32'h1111_2222;
    #1 check("b_d_done", {30'b0, d_done, i_done}, 32'h2);
    tick();
    m_data_ok = 1'b0; d_req = 1'b0;
    #1 check("b_idle_gap", {31'b0, bus_req}, 32'h0);
    tick();
    check("b_second_addr", bus_addr, 32'hBFC0_0010);
    m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h3333_4444;
    #1 check("b_i_done", {30'b0, d_done, i_done}, 32'h1);
    tick();
    m_data_ok = 1'b0; i_req = 1'b0;
    tick();

    // Flush during DATA: fetch is dropped, a new fetch is served afterwards
    i_req = 1'b1; i_addr = 32'hBFC0_0100; i_q.push_back(32'hDEAD_BEEF);
    tick();
    m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0; flush = 1'b1; i_req = 1'b0;
    tick();
    flush = 1'b0;
    tick();
    m_data_ok = 1'b1; m_rdata = 32'hDEAD_BEEF;
    #1 check("c_no_i_done", {31'b0, i_done}, 32'h0);
    i_req = 1'b1; i_addr = 32'hBFC0_0380; i_q.push_back(32'h1234_5678);
    tick();
    m_data_ok = 1'b0;
    tick();
    check("c_new_addr", bus_addr, 32'hBFC0_0380);
    check("c_new_req", {31'b0, bus_req}, 32'h1);
    m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h1234_5678;
    #1 check("c_i_done", {31'b0, i_done}, 32'h1);
    tick();
    m_data_ok = 1'b0; i_req = 1'b0;
    tick();

    // Flush during ADDR without acceptance: request withdrawn
    i_req = 1'b1; i_addr = 32'hBFC0_0200; i_q.push_back(32'h0);
    tick();
    check("d_bus_req", {31'b0, bus_req}, 32'h1);
    flush = 1'b1; i_req = 1'b0;
    tick();
    flush = 1'b0;
    check("d_abort_req", {31'b0, bus_req}, 32'h0);
    repeat (3) tick();
    check("d_still_idle", {31'b0, bus_req}, 32'h0);

    // Byte store
    d_req = 1'b1; d_wr = 1'b1; d_size = 2'b00; d_addr = 32'h8000_0003; d_wdata = 32'h0000_00AB;
    d_q.push_back(32'h0);
    tick();
    check("e_bus_wr_size", {29'b0, bus_wr, bus_size}, 32'h4);
    check("e_bus_wdata", bus_wdata, 32'h0000_00AB);
    m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0;
    tick();
    m_data_ok = 1'b1; m_rdata = 32'h0;
    #1 check("e_d_done", {31'b0, d_done}, 32'h1);
    tick();
    m_data_ok = 1'b0; d_req = 1'b0;
    tick();

    // Reset while in DATA: no completion, late data_ok ignored
    d_req = 1'b1; d_wr = 1'b0; d_size = 2'b10; d_addr = 32'h8000_2000;
    tick();
    m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0; resetn = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h5555_5555;
    #1 check("f_rst_bus_req", {31'b0, bus_req}, 32'h0);
    check("f_rst_bus_addr", bus_addr, 32'h0);
    check("f_rst_d_done", {31'b0, d_done}, 32'h0);
    tick();
    d_req = 1'b0; resetn = 1'b1;
    #1 check("f_late_data_ok", {30'b0, d_done, i_done}, 32'h0);
    tick();
    m_data_ok = 1'b0;
    tick();

    // Both requests held continuously
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    base = addr_log.size();
    i_addr = 32'hBFC0_0000; d_addr = 32'h8000_1000; d_wr = 1'b0; d_size = 2'b10;
    for (int n = 0; n < 8; n++) begin
      i_q.push_back(mem_fn(i_addr));
      d_q.push_back(mem_fn(d_addr));
    end
    slave_auto = 1'b1; i_req = 1'b1; d_req = 1'b1;
    k = 0;
    while (addr_log.size() < base + 4 && k < 300) begin tick(); k++; end
    if (addr_log.size() < base + 4) check("g_timeout", 32'(addr_log.size() - base), 32'd4);
    else begin
      for (int n = 0; n < 4; n++) begin
`ifdef ARB_ROUND_ROBIN_EN
        check("g_grant_order", addr_log[base + n], (n % 2 == 0) ? 32'h8000_1000 : 32'hBFC0_0000);
`else
        check("g_grant_order", addr_log[base + n], 32'h8000_1000);
`endif
      end
    end
    resetn = 1'b0; i_req = 1'b0; d_req = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();

    // Randomized traffic with random flushes
    for (int n = 0; n < 3000; n++) drive_cycle(1'b1);
    k = 0;
    while ((i_busy || d_busy) && k < 300) begin drive_cycle(1'b0); k++; end
    check("drain_busy", {30'b0, i_busy, d_busy}, 32'h0);
    repeat (10) drive_cycle(1'b0);
    check("drain_i_q", 32'(i_q.size()), 32'h0);
    check("drain_d_q", 32'(d_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and resetn (input, 1, asynchronous active-low reset).
REQ-002 flush  input  1  pipeline flush from the exception controller; cancels or drops the in-flight instruction-side access.
REQ-003 i_req  input  1  instruction fetch request; held high with i_addr stable until i_done.
REQ-004 i_addr  input  32  fetch address, word-aligned.
REQ-005 i_rdata / i_done  output  32 / 1  fetch data; one-cycle completion strobe.
REQ-006 d_req / d_wr  input  1 / 1  data request; 1 = store, 0 = load; held with all d_* stable until d_done.
REQ-007 d_size  input  2  access size: 00 byte, 01 half, 10 word.
REQ-008 d_addr / d_wdata  input  32 / 32  data address; store data.
REQ-009 d_rdata / d_done  output  32 / 1  load data; one-cycle completion strobe.
REQ-010 bus_req / bus_wr / bus_size  output  1 / 1 / 2  shared SRAM-like bus request, direction, size.
REQ-011 bus_addr / bus_wdata  output  32 / 32  bus address and write data, driven from internal registers.
REQ-012 bus_addr_ok / bus_data_ok  input  1 / 1  address accepted; data returned or write complete.
REQ-013 bus_rdata  input  32  bus read data, valid while bus_data_ok=1.
REQ-014 stall_req  output  1  pipeline stall request to the control unit.

Function
REQ-015 The FSM SHALL have states IDLE, ADDR, DATA, holding at most one bus transaction outstanding.
REQ-016 In IDLE, d_req=1 SHALL win over i_req=1; the winner's address, wr, size and wdata are registered together with owner, and the FSM enters ADDR on the next edge.
REQ-017 Instruction accesses SHALL drive bus_wr=0 and bus_size=10.
REQ-018 In ADDR, bus_req SHALL be 1; on bus_addr_ok=1 the FSM SHALL enter DATA with bus_req=0 from the next cycle.
REQ-019 In DATA, on bus_data_ok=1 the owner's done SHALL be high in that same cycle with rdata=bus_rdata combinationally, and the FSM SHALL return to IDLE.
REQ-020 Minimum latency, request to done: 2 cycles (IDLE grant, ADDR with addr_ok, then DATA with data_ok); done, not the FSM, bounds requester hold time.
REQ-021 i_done and d_done SHALL never be high in the same cycle; the non-owner's done and rdata SHALL be 0.
REQ-022 flush=1 with owner=I in ADDR and bus_addr_ok=0 SHALL abort to IDLE with no bus transaction and no i_done.
REQ-023 flush=1 with owner=I in ADDR (bus_addr_ok=1) or in DATA SHALL set a drop flag; the transaction completes on the bus, i_done is suppressed, and the flag clears on return to IDLE.
REQ-024 flush SHALL have no effect on data-side transactions or on an IDLE grant decision made in the same cycle.
REQ-025 stall_req SHALL equal (i_req & ~i_done & ~flush) | (d_req & ~d_done).
REQ-026 A request arriving while the FSM is busy SHALL wait with no loss, and is granted in the first IDLE cycle after done.

Reset
REQ-027 resetn=0 SHALL immediately force IDLE, clear owner, drop flag and the priority pointer, zero bus_addr/bus_wdata/bus_size/bus_wr, and hold bus_req, i_done, d_done at 0.
REQ-028 Reset during ADDR or DATA SHALL abandon the transaction without any done; a bus_data_ok arriving after reset is ignored.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-030 When defined, if both requests are pending in IDLE, the requester not served last is granted; a single pending request is always granted. The last-served pointer resets to I, so D wins first.
REQ-031 When undefined, fixed D-over-I priority per REQ-016, and no pointer register exists.

Verification
REQ-032 i_req=1 with i_addr=0xBFC00000; addr_ok in cycle 2, data_ok=1 in cycle 4 with rdata=0x3C080001 -> i_done pulses in cycle 4 with i_rdata=0x3C080001; stall_req=0 in cycle 5.
REQ-033 i_req and d_req (load from 0x80001000) both rise together -> bus_addr=0x80001000 first, and the fetch is issued only after d_done.
REQ-034 Fetch in DATA, flush pulses one cycle, data_ok later -> no i_done; the FSM returns to IDLE and accepts a new i_req at 0xBFC00380.
REQ-035 Fetch in ADDR with addr_ok=0 and flush=1 -> bus_req=0 next cycle, and no data_ok is expected.
REQ-036 Store d_wr=1, d_size=00, d_addr=0x80000003, d_wdata=0xAB -> bus_wr=1, bus_size=00, and d_done on data_ok.
REQ-037 With ARB_ROUND_ROBIN_EN, both requests held continuously -> grants alternate D, I, D, I; resetn low in DATA -> bus_req=0 and no done.
